// File: rtl/rail_monitor.sv
// Rail monitor: samples each rail on a fixed-rate tick and box-car averages it.
// Each average is checked against per-rail limits and debounced into sticky fault flags.
`timescale 1ns/1ps
module rail_monitor #(
   parameter int SYSCLK_FREQ = 100_000_000,
   parameter int NUMADCS     = 5,
   parameter int SAMPLE_HZ   = 10_000,
   parameter int AVG_LOG2    = 3,
   parameter int FAULT_COUNT = 4
) (
   input  logic                    sclk,
   input  logic                    rstn,
   input  logic [NUMADCS-1:0][7:0] railData,
   input  logic [NUMADCS-1:0][7:0] underThresh,
   input  logic [NUMADCS-1:0][7:0] overThresh,
   input  logic [NUMADCS-1:0]      faultClear,
   output logic [NUMADCS-1:0][7:0] avgData,
   output logic                    avgValid,
   output logic [NUMADCS-1:0]      underFault,
   output logic [NUMADCS-1:0]      overFault,
   output logic                    faultIrq
);

   localparam int TICK_DIV = SYSCLK_FREQ / SAMPLE_HZ;
   localparam int TW       = $clog2(TICK_DIV);
   localparam int ACC_W    = 8 + AVG_LOG2;
   localparam int SW       = AVG_LOG2 + 1;
   localparam int CW       = $clog2(FAULT_COUNT + 1);

   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'((1 << AVG_LOG2) - 1);
   localparam logic [CW-1:0] CNT_MAX     = CW'(FAULT_COUNT);

   typedef enum logic [1:0] {ACCUM, AVG, EVAL} state_t;

   state_t                       state, state_next;
   logic [TW-1:0]                tick_cnt;
   logic                         tick;
   logic [SW-1:0]                sample_cnt;
   logic [NUMADCS-1:0][ACC_W-1:0] acc, acc_sum;
   logic                         window_done;

   assign tick        = (tick_cnt == TICK_LAST);
   assign window_done = (state == ACCUM) && tick && (sample_cnt == SAMPLE_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) state <= ACCUM;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (window_done) state_next = AVG;
         AVG:     state_next = EVAL;
         EVAL:    state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   always_comb begin
      acc_sum = '0;
      for (int i = 0; i < NUMADCS; i++) begin
         acc_sum[i] = acc[i] + ACC_W'(railData[i]);
      end
   end

   // The average is captured from the running sum as the final sample lands, so
   // avgData and avgValid are both presented during the AVG cycle.
   // NOTE: the accumulator bank is cleared by reset so a window cut short by
   // reset never leaks samples into the next average.
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         acc        <= '0;
         sample_cnt <= '0;
         avgData    <= '0;
         avgValid   <= 1'b0;
      end else begin
         avgValid <= window_done;
         if (state == AVG) begin
            acc        <= '0;
            sample_cnt <= '0;
         end else if (state == ACCUM && tick) begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + SW'(1);
         end
         if (window_done) begin
            for (int i = 0; i < NUMADCS; i++) begin
               avgData[i] <= acc_sum[i][ACC_W-1:AVG_LOG2];
            end
         end
      end
   end

   for (genvar g = 0; g < NUMADCS; g++) begin : g_rail
      logic          under_hit, over_hit;
      logic [CW-1:0] u_cnt, o_cnt, u_inc, o_inc;
      logic          u_flag, o_flag;

      assign under_hit = (avgData[g] < underThresh[g]);
      assign over_hit  = (avgData[g] > overThresh[g]);
      assign u_inc     = (u_cnt == CNT_MAX) ? CNT_MAX : u_cnt + CW'(1);
      assign o_inc     = (o_cnt == CNT_MAX) ? CNT_MAX : o_cnt + CW'(1);

      // In EVAL a set event outranks a simultaneous clear; elsewhere clear wins.
      always_ff @(posedge sclk or negedge rstn) begin
         if (!rstn) begin
            u_cnt  <= '0;
            o_cnt  <= '0;
            u_flag <= 1'b0;
            o_flag <= 1'b0;
         end else if (state == EVAL) begin
            u_cnt <= under_hit ? u_inc : '0;
            o_cnt <= over_hit  ? o_inc : '0;
            if (under_hit && u_inc == CNT_MAX) u_flag <= 1'b1;
            else if (faultClear[g])            u_flag <= 1'b0;
            if (over_hit && o_inc == CNT_MAX)  o_flag <= 1'b1;
            else if (faultClear[g])            o_flag <= 1'b0;
         end else if (faultClear[g]) begin
            u_cnt  <= '0;
            o_cnt  <= '0;
            u_flag <= 1'b0;
            o_flag <= 1'b0;
         end
      end

      assign underFault[g] = u_flag;
      assign overFault[g]  = o_flag;
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) faultIrq <= 1'b0;
      else       faultIrq <= (|underFault) | (|overFault);
   end

endmodule

// File: tb/tb_rail_monitor.sv
// Directed bench for rail_monitor: averaging, debounce, clear priority, reset mid-window,
// plus a second instance with 64-sample windows at full scale.
`timescale 1ns/1ps
module tb_rail_monitor;

   localparam int N = 5;

   logic sclk = 1'b0;
   logic rstn = 1'b0;

   logic [N-1:0][7:0] rail_a, under_a, over_a, avg_a;
   logic [N-1:0]      clr_a, uf_a, of_a;
   logic              valid_a, irq_a;

   logic [N-1:0][7:0] rail_b, under_b, over_b, avg_b;
   logic [N-1:0]      clr_b, uf_b, of_b;
   logic              valid_b, irq_b;

   int n_checks = 0;
   int n_pass   = 0;
   int to_tick  = 10;

   rail_monitor #(
      .SYSCLK_FREQ(100), .NUMADCS(N), .SAMPLE_HZ(10), .AVG_LOG2(2), .FAULT_COUNT(2)
   ) dut_a (
      .sclk(sclk), .rstn(rstn), .railData(rail_a), .underThresh(under_a),
      .overThresh(over_a), .faultClear(clr_a), .avgData(avg_a), .avgValid(valid_a),
      .underFault(uf_a), .overFault(of_a), .faultIrq(irq_a)
   );

   rail_monitor #(
      .SYSCLK_FREQ(100), .NUMADCS(N), .SAMPLE_HZ(10), .AVG_LOG2(6), .FAULT_COUNT(4)
   ) dut_b (
      .sclk(sclk), .rstn(rstn), .railData(rail_b), .underThresh(under_b),
      .overThresh(over_b), .faultClear(clr_b), .avgData(avg_b), .avgValid(valid_b),
      .underFault(uf_b), .overFault(of_b), .faultIrq(irq_b)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One negedge; to_tick tracks negedges left until the one just after a tick edge.
   task automatic step();
      @(negedge sclk);
      to_tick--;
      if (to_tick == 0) to_tick = 10;
   endtask

   task automatic tick();
      repeat (to_tick) step();
   endtask

   // Four ticks then two more cycles: returns where EVAL results are visible.
   task automatic window_flags();
      repeat (4) tick();
      step();
      step();
   endtask

   task automatic do_reset();
      @(negedge sclk);
      rstn    = 1'b0;
      rail_a  = '0;
      under_a = '0;
      over_a  = '1;
      clr_a   = '0;
      repeat (2) @(negedge sclk);
      rstn    = 1'b1;
      to_tick = 10;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rail_a  = '0;
      under_a = '0;
      over_a  = '1;
      clr_a   = '0;
      rail_b  = '1;
      under_b = '1;
      over_b  = '1;
      clr_b   = '0;

      // Reset state
      repeat (2) @(negedge sclk);
      check("rst_avg",   avg_a,   '0);
      check("rst_valid", valid_a, 1'b0);
      check("rst_under", uf_a,    '0);
      check("rst_over",  of_a,    '0);
      check("rst_irq",   irq_a,   1'b0);
      rstn    = 1'b1;
      to_tick = 10;

      // 64-sample windows at full scale: no wrap, equality to 255 limits is in range
      repeat (63) tick();
      check("b_no_early_valid", valid_b, 1'b0);
      tick();
      check("b_valid", valid_b, 1'b1);
      check("b_avg_255", avg_b, {N{8'hFF}});
      step();
      step();
      check("b_under", uf_b, '0);
      check("b_over",  of_b, '0);

      // Averaging: rail0 10,11,12,14 -> 11; rail4 0,100,200,255 -> 138
      do_reset();
      rail_a[0] = 8'd10; rail_a[4] = 8'd0;   tick();
      check("avg_no_valid_t1", valid_a, 1'b0);
      rail_a[0] = 8'd11; rail_a[4] = 8'd100; tick();
      check("avg_no_valid_t2", valid_a, 1'b0);
      rail_a[0] = 8'd12; rail_a[4] = 8'd200; tick();
      check("avg_no_valid_t3", valid_a, 1'b0);
      rail_a[0] = 8'd14; rail_a[4] = 8'd255; tick();
      check("avg_valid", valid_a, 1'b1);
      check("avg_rail0", avg_a[0], 8'd11);
      check("avg_rail4", avg_a[4], 8'd138);
      check("avg_rail1", avg_a[1], 8'd0);
      step();
      check("avg_valid_pulse", valid_a, 1'b0);

      // Undervoltage debounce, FAULT_COUNT=2
      do_reset();
      under_a[2] = 8'd100;
      rail_a[2]  = 8'd99;
      window_flags();
      check("uv_win1_flag", uf_a, 5'b00000);
      step();
      check("uv_win1_irq", irq_a, 1'b0);
      window_flags();
      check("uv_win2_flag", uf_a, 5'b00100);
      check("uv_irq_lag", irq_a, 1'b0);
      check("uv_over_quiet", of_a, 5'b00000);
      step();
      check("uv_irq", irq_a, 1'b1);

      // Debounce reset: 200, 150 (equal, in range), 200, 200
      do_reset();
      over_a[1] = 8'd150;
      rail_a[1] = 8'd200; window_flags();
      check("db_w1", of_a, 5'b00000);
      rail_a[1] = 8'd150; window_flags();
      check("db_w2_equal", of_a, 5'b00000);
      rail_a[1] = 8'd200; window_flags();
      check("db_w3", of_a, 5'b00000);
      window_flags();
      check("db_w4_set", of_a, 5'b00010);

      // Boundary: readings equal to both limits
      do_reset();
      under_a = {N{8'd128}};
      over_a  = {N{8'd128}};
      rail_a  = {N{8'd128}};
      window_flags();
      window_flags();
      check("bnd_avg",   avg_a, {N{8'd128}});
      check("bnd_under", uf_a,  5'b00000);
      check("bnd_over",  of_a,  5'b00000);
      step();
      check("bnd_irq", irq_a, 1'b0);

      // Clear interaction on rail3
      do_reset();
      over_a[3] = 8'd100;
      rail_a[3] = 8'd200;
      window_flags();
      check("clr_w1", of_a, 5'b00000);
      window_flags();
      check("clr_set", of_a, 5'b01000);
      step();
      check("clr_irq_set", irq_a, 1'b1);
      clr_a[3] = 1'b1;
      step();
      clr_a[3] = 1'b0;
      check("clr_flag", of_a, 5'b00000);
      step();
      check("clr_irq_drop", irq_a, 1'b0);
      window_flags();
      check("clr_cnt_reset", of_a, 5'b00000);
      repeat (4) tick();
      step();
      clr_a[3] = 1'b1;
      step();
      clr_a[3] = 1'b0;
      check("clr_set_wins", of_a, 5'b01000);
      step();
      check("clr_set_irq", irq_a, 1'b1);

      // Reset mid-window after 2 of 4 ticks
      rail_a[0] = 8'd200;
      tick();
      tick();
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_avg",   avg_a,   '0);
      check("mid_rst_valid", valid_a, 1'b0);
      check("mid_rst_over",  of_a,    '0);
      check("mid_rst_irq",   irq_a,   1'b0);
      @(negedge sclk);
      rstn    = 1'b1;
      to_tick = 10;
      rail_a[0] = 8'd4;  tick();
      rail_a[0] = 8'd8;  tick();
      check("mid_no_valid_t2", valid_a, 1'b0);
      rail_a[0] = 8'd12; tick();
      check("mid_no_valid_t3", valid_a, 1'b0);
      rail_a[0] = 8'd16; tick();
      check("mid_valid", valid_a, 1'b1);
      check("mid_avg", avg_a[0], 8'd10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rail_monitor.md
Name: rail_monitor

Overview:
Downstream consumer of the rail-sensor ADC bank. Takes the per-rail 8-bit readings, samples them on a fixed-rate tick, and box-car averages each channel over 2^AVG_LOG2 samples. It compares every average against per-rail under/over thresholds with a consecutive-window debounce, and raises sticky fault flags plus a combined interrupt for the rover supervisor.

Parameters:
SYSCLK_FREQ, 100_000_000, sclk frequency in Hz
NUMADCS, 5, number of monitored rails; matches the rail-sensor bank width
SAMPLE_HZ, 10_000, sample tick rate; TICK_DIV = SYSCLK_FREQ/SAMPLE_HZ, must be >= 4
AVG_LOG2, 3, log2 of samples per averaging window; range 0..6
FAULT_COUNT, 4, consecutive out-of-range windows before a fault latches; must be >= 1

Ports:
sclk  input  1  system clock
rstn  input  1  asynchronous active-low reset
railData  input  [NUMADCS-1:0][7:0]  live 8-bit readings from the rail-sensor bank
underThresh  input  [NUMADCS-1:0][7:0]  per-rail low limit; quasi-static
overThresh  input  [NUMADCS-1:0][7:0]  per-rail high limit; quasi-static
faultClear  input  [NUMADCS-1:0]  per-rail clear of sticky flags and debounce counters
avgData  output  [NUMADCS-1:0][7:0]  latest completed window average per rail
avgValid  output  1  one-cycle pulse when avgData updates
underFault  output  [NUMADCS-1:0]  sticky undervoltage flags
overFault  output  [NUMADCS-1:0]  sticky overvoltage flags
faultIrq  output  1  registered OR of all underFault and overFault bits

Behaviour:
- Reset (async assert, sync release): tick counter, sample counter, accumulators, debounce counters, avgData, avgValid, underFault, overFault and faultIrq all go to 0; FSM goes to ACCUM. Any partial window in progress is discarded.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 on the cycle where counter==TICK_DIV-1. First tick is TICK_DIV cycles after reset release.
- Accumulators: one per rail, each 8+AVG_LOG2 bits, so overflow cannot occur.
- FSM states: ACCUM, AVG, EVAL.
- ACCUM:
  - On tick, acc[i] += railData[i], using railData as presented on the tick cycle. sampleCnt increments.
  - If sampleCnt was 2^AVG_LOG2-1 at that tick, go to AVG.
- AVG (1 cycle):
  - avgData[i] = acc[i] >> AVG_LOG2 (truncate, no rounding).
  - avgValid=1 for this one cycle.
  - acc and sampleCnt cleared. Next state EVAL.
- EVAL (1 cycle), per rail:
  - under condition: avgData < underThresh. Otherwise uCnt resets to 0.
  - over condition: avgData > overThresh. Otherwise oCnt resets to 0.
  - Equality to either threshold is in range.
  - Each counter increments while its condition holds and saturates at FAULT_COUNT.
  - When a counter reaches FAULT_COUNT, the matching sticky flag sets.
  - Both conditions may fire together if underThresh > overThresh; each counter is independent.
  - Next state ACCUM.
- Ticks never land in AVG or EVAL because TICK_DIV >= 4.
- Latency: avgValid is high 1 cycle after the final tick of a window. Flags update 2 cycles after that tick. faultIrq follows 1 cycle after the flags.
- faultClear[i]:
  - Any cycle: clears underFault[i], overFault[i], uCnt[i] and oCnt[i].
  - Asserted in EVAL: the set event wins over the clear; the counter still increments normally.
- Thresholds are sampled only in EVAL.
- AVG_LOG2=0: every tick is a complete window.

Test Plan:
- Averaging: SYSCLK_FREQ=100, SAMPLE_HZ=10, AVG_LOG2=2. Rail0 fed 10,11,12,14 on successive ticks -> avgData[0]=11 (47>>2), avgValid single pulse 1 cycle after the 4th tick; no pulse during the first 3 ticks.
- Undervoltage debounce: FAULT_COUNT=2, underThresh[2]=100, constant railData[2]=99 -> underFault[2] stays 0 after window 1 and sets in EVAL of window 2; faultIrq=1 one cycle later.
- Debounce reset: railData[1]=200, overThresh[1]=150 for one window, then 150 for one window, then 200 for one window -> overFault[1] stays 0. Then 200 for a second consecutive window -> overFault[1]=1.
- Boundary and max-value: railData=underThresh=overThresh=128 -> no flags. All rails at 255 with AVG_LOG2=6 -> avgData=255, no wrap.
- Clear interaction: overFault[3] set, faultClear[3] pulsed outside EVAL -> flag and counter cleared, faultIrq drops next cycle. faultClear[3] held through an EVAL that meets FAULT_COUNT -> flag reads 1.
- Reset mid-window: rstn asserted after 2 of 4 ticks -> all outputs 0 immediately. Next avgValid arrives only after 4 fresh ticks, and the average excludes pre-reset samples.
